pc_sequencer: RTL

Parametrised program-counter sequencer for the multi-cycle pipelined RISC-V core. It generates the fetch address and supports sequential increment, relative and absolute redirects, pipeline stall, and a halt/resume state machine. It also keeps a retired-advance counter. It sits at the head of the fetch stage and feeds the instruction memory address.

---
 rtl/pc_sequencer_if.sv | 41 ++++
 rtl/pc_sequencer.sv | 131 +++++++++++++
 2 files changed

// File: rtl/pc_sequencer_if.sv
// Fetch-side bus of pc_sequencer: redirect/stall/halt controls in, fetch address and status out.
// Optional return-address-stack signals are present only when PC_RAS_EN is defined.
interface pc_sequencer_if #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned CNT_WIDTH = 16
);
    logic                 stall;
    logic [6:0]           opcode;
    logic                 redir_valid;
    logic                 redir_abs;
    logic [WIDTH-1:0]     redir_target;
    logic                 resume;
    logic [WIDTH-1:0]     pc;
    logic [WIDTH-1:0]     pc_plus_inc;
    logic                 halted;
    logic                 misalign;
    logic [CNT_WIDTH-1:0] adv_count;
`ifdef PC_RAS_EN
    logic                 ras_push;
    logic                 ras_pop;
    logic                 ras_empty;

    modport master (
        output stall, opcode, redir_valid, redir_abs, redir_target, resume, ras_push, ras_pop,
        input  pc, pc_plus_inc, halted, misalign, adv_count, ras_empty
    );
    modport slave (
        input  stall, opcode, redir_valid, redir_abs, redir_target, resume, ras_push, ras_pop,
        output pc, pc_plus_inc, halted, misalign, adv_count, ras_empty
    );
`else
    modport master (
        output stall, opcode, redir_valid, redir_abs, redir_target, resume,
        input  pc, pc_plus_inc, halted, misalign, adv_count
    );
    modport slave (
        input  stall, opcode, redir_valid, redir_abs, redir_target, resume,
        output pc, pc_plus_inc, halted, misalign, adv_count
    );
`endif
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer at the head of fetch: increment, redirect, stall, halt/resume, advance counter.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_sequencer #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int unsigned      INC       = 4,
    parameter logic [6:0]       HALT_OP   = 7'h7F,
    parameter int unsigned      CNT_WIDTH = 16,
    parameter int unsigned      RAS_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    pc_sequencer_if.slave  bus
);
    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] HALT = 1'b1;

    localparam logic [WIDTH-1:0] INC_W    = WIDTH'(INC);
    localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'(INC - 1);

    logic [0:0]           state_q, state_d;
    logic [WIDTH-1:0]     pc_q, pc_d;
    logic                 misalign_q, misalign_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]     pc_inc;
    logic [WIDTH-1:0]     raw_tgt;
    logic                 take_redir;

`ifdef PC_RAS_EN
    localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned NW = $clog2(RAS_DEPTH + 1);

    logic [WIDTH-1:0] ras_mem_q [RAS_DEPTH];
    logic [PW-1:0]    ras_ptr_q;
    logic [NW-1:0]    ras_n_q;
    logic [PW-1:0]    ras_top;
    logic             ras_hit;
    logic             do_pop, do_push;

    // ras_ptr_q is the next write slot; the top of stack sits just below it, circularly
    assign ras_top       = (ras_ptr_q == '0) ? PW'(RAS_DEPTH - 1) : ras_ptr_q - 1'b1;
    assign ras_hit       = bus.ras_pop && (ras_n_q != '0);
    assign do_pop        = take_redir && ras_hit;
    assign do_push       = take_redir && bus.ras_push;
    assign bus.ras_empty = (ras_n_q == '0);
`endif

    always_comb begin
        pc_inc  = pc_q + INC_W;
        raw_tgt = bus.redir_abs ? bus.redir_target : pc_q + bus.redir_target;
`ifdef PC_RAS_EN
        if (ras_hit) begin
            raw_tgt = ras_mem_q[ras_top];
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        misalign_d = 1'b0;
        cnt_d      = cnt_q;
        take_redir = 1'b0;
        case (state_q)
            RUN: begin
                if (bus.redir_valid) begin
                    take_redir = 1'b1;
                    pc_d       = raw_tgt & ~LOW_MASK;
                    misalign_d = |(raw_tgt & LOW_MASK);
                    cnt_d      = cnt_q + 1'b1;
                end else if (bus.stall) begin
                    pc_d = pc_q;
                end else if (bus.opcode == HALT_OP) begin
                    state_d = HALT;
                end else begin
                    pc_d  = pc_inc;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HALT: begin
                if (bus.resume) begin
                    state_d = RUN;
                    pc_d    = pc_inc;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= RUN;
            pc_q       <= RESET_VEC;
            misalign_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
            cnt_q      <= cnt_d;
        end
    end

`ifdef PC_RAS_EN
    // Pop-then-push replaces the top in place, leaving depth unchanged
    always_ff @(posedge clk) begin
        if (!rst) begin
            ras_ptr_q <= '0;
            ras_n_q   <= '0;
        end else if (do_pop && do_push) begin
            ras_mem_q[ras_top] <= pc_inc;
        end else if (do_pop) begin
            ras_ptr_q <= ras_top;
            ras_n_q   <= ras_n_q - 1'b1;
        end else if (do_push) begin
            ras_mem_q[ras_ptr_q] <= pc_inc;
            ras_ptr_q <= (ras_ptr_q == PW'(RAS_DEPTH - 1)) ? '0 : ras_ptr_q + 1'b1;
            if (ras_n_q != NW'(RAS_DEPTH)) begin
                ras_n_q <= ras_n_q + 1'b1;
            end
        end
    end
`endif

    assign bus.pc          = pc_q;
    assign bus.pc_plus_inc = pc_inc;
    assign bus.halted      = (state_q == HALT);
    assign bus.misalign    = misalign_q;
    assign bus.adv_count   = cnt_q;
endmodule
